motion_bbox_tracker: RTL and testbench

MOTION_BBOX_TRACKER -- requirements
Module: motion_bbox_tracker

---
 rtl/motion_bbox_tracker.sv | 140 ++++++++++++++
 tb/tb_motion_bbox_tracker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/motion_bbox_tracker.sv
// Motion bounding-box tracker: accumulates the box and pixel count of nonzero mask pixels per frame.
// Optional `MOTION_DENOISE_EN: a pixel counts only if 2 of {x-1,x,x+1} in its line are motion.
module motion_bbox_tracker #(
  parameter int H_ACTIVE     = 800,
  parameter int V_ACTIVE     = 600,
  parameter int COUNT_THRESH = 64
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFVAL,
  input  logic        iDVAL,
  input  logic [9:0]  iMASK,
  input  logic        iREADY,
  output logic [10:0] oX_MIN,
  output logic [10:0] oX_MAX,
  output logic [10:0] oY_MIN,
  output logic [10:0] oY_MAX,
  output logic [19:0] oCOUNT,
  output logic        oMOTION,
  output logic        oVALID,
  output logic        oOVERRUN
);
  localparam logic [10:0] XLAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0] YEND  = 11'(V_ACTIVE);
  localparam logic [19:0] THR   = 20'(COUNT_THRESH);

  typedef enum logic [1:0] {WAIT_FRAME, ACCUM, LATCH} state_t;
  state_t state_q;

  logic        fval_q;
  logic [10:0] x_q, y_q, xmin_q, xmax_q, ymin_q, ymax_q;
  logic [19:0] cnt_q, cnt_d;
  logic [10:0] rxmin_q, rxmax_q, rymin_q, rymax_q;
  logic [19:0] rcnt_q;
  logic        rmot_q, vld_q, ovr_q;

  logic        pix_en, cur, x_last, hit_a, hit_b, any_hit;
  logic [10:0] ax, lo_x, hi_x;
  logic [1:0]  inc;
  logic [20:0] cnt_sum;
`ifdef MOTION_DENOISE_EN
  logic        p1_q, p2_q;
  logic [1:0]  votes;
`endif

  always_comb begin
    pix_en = (state_q == ACCUM) && iDVAL && (y_q < YEND);
    cur    = |iMASK;
    x_last = (x_q == XLAST);
`ifdef MOTION_DENOISE_EN
    // hit_a decides centre x-1 now that its right neighbour has arrived; hit_b closes the line
    votes  = {1'b0, p2_q} + {1'b0, p1_q} + {1'b0, cur};
    hit_a  = pix_en && (x_q != 11'd0) && (votes >= 2'd2);
    hit_b  = pix_en && x_last && p1_q && cur;
    ax     = x_q - 11'd1;
`else
    hit_a  = pix_en && cur;
    hit_b  = 1'b0;
    ax     = x_q;
`endif
    any_hit = hit_a || hit_b;
    lo_x    = hit_a ? ax : x_q;
    hi_x    = hit_b ? x_q : ax;
    inc     = {1'b0, hit_a} + {1'b0, hit_b};
    cnt_sum = {1'b0, cnt_q} + {19'd0, inc};
    cnt_d   = cnt_sum[20] ? 20'hFFFFF : cnt_sum[19:0];
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= WAIT_FRAME;
      // fval_q comes out of reset high so a frame already running at release is not mistaken for a start
      fval_q  <= 1'b1;
      x_q     <= '0; y_q    <= '0; cnt_q  <= '0;
      xmin_q  <= '0; xmax_q <= '0; ymin_q <= '0; ymax_q <= '0;
      rxmin_q <= '0; rxmax_q <= '0; rymin_q <= '0; rymax_q <= '0;
      rcnt_q  <= '0; rmot_q <= 1'b0; vld_q <= 1'b0; ovr_q <= 1'b0;
`ifdef MOTION_DENOISE_EN
      p1_q <= 1'b0; p2_q <= 1'b0;
`endif
    end else begin
      fval_q <= iFVAL;
      if (vld_q && iREADY) vld_q <= 1'b0;
      case (state_q)
        WAIT_FRAME: if (!fval_q && iFVAL) begin
          state_q <= ACCUM;
          x_q <= '0; y_q <= '0; cnt_q <= '0;
          xmin_q <= 11'h7FF; ymin_q <= 11'h7FF; xmax_q <= '0; ymax_q <= '0;
`ifdef MOTION_DENOISE_EN
          p1_q <= 1'b0; p2_q <= 1'b0;
`endif
        end
        ACCUM: begin
          if (fval_q && !iFVAL) state_q <= LATCH;
          if (pix_en) begin
            if (x_last) begin
              x_q <= '0;
              y_q <= y_q + 11'd1;
            end else begin
              x_q <= x_q + 11'd1;
            end
`ifdef MOTION_DENOISE_EN
            p2_q <= x_last ? 1'b0 : p1_q;
            p1_q <= x_last ? 1'b0 : cur;
`endif
          end
          if (any_hit) begin
            cnt_q <= cnt_d;
            if (lo_x < xmin_q) xmin_q <= lo_x;
            if (hi_x > xmax_q) xmax_q <= hi_x;
            if (y_q < ymin_q)  ymin_q <= y_q;
            if (y_q > ymax_q)  ymax_q <= y_q;
          end
        end
        LATCH: begin
          state_q <= WAIT_FRAME;
          if (cnt_q == 20'd0) begin
            rxmin_q <= '0; rxmax_q <= '0; rymin_q <= '0; rymax_q <= '0;
          end else begin
            rxmin_q <= xmin_q; rxmax_q <= xmax_q; rymin_q <= ymin_q; rymax_q <= ymax_q;
          end
          rcnt_q <= cnt_q;
          rmot_q <= (cnt_q >= THR);
          vld_q  <= 1'b1;
          if (vld_q && !iREADY) ovr_q <= 1'b1;
        end
        default: state_q <= WAIT_FRAME;
      endcase
    end
  end

  assign oX_MIN   = rxmin_q;
  assign oX_MAX   = rxmax_q;
  assign oY_MIN   = rymin_q;
  assign oY_MAX   = rymax_q;
  assign oCOUNT   = rcnt_q;
  assign oMOTION  = rmot_q;
  assign oVALID   = vld_q;
  assign oOVERRUN = ovr_q;
endmodule

// File: tb/tb_motion_bbox_tracker.sv
// Scoreboard bench for motion_bbox_tracker on an 8x4 frame; expectations follow `MOTION_DENOISE_EN.
module tb_motion_bbox_tracker;
  logic        iCLK = 1'b0, iRST = 1'b1, iFVAL = 1'b0, iDVAL = 1'b0, iREADY = 1'b1;
  logic [9:0]  iMASK = '0;
  logic [10:0] oX_MIN, oX_MAX, oY_MIN, oY_MAX;
  logic [19:0] oCOUNT;
  logic        oMOTION, oVALID, oOVERRUN;

  motion_bbox_tracker #(.H_ACTIVE(8), .V_ACTIVE(4), .COUNT_THRESH(3)) dut (
    .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL), .iMASK(iMASK), .iREADY(iREADY),
    .oX_MIN(oX_MIN), .oX_MAX(oX_MAX), .oY_MIN(oY_MIN), .oY_MAX(oY_MAX),
    .oCOUNT(oCOUNT), .oMOTION(oMOTION), .oVALID(oVALID), .oOVERRUN(oOVERRUN));

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [10:0] xmin, xmax, ymin, ymax;
    logic [19:0] cnt;
    logic        mot, ovr;
  } exp_t;
  exp_t sbq[$];

  int checks = 0, failures = 0, results = 0, pushed = 0;
  logic [9:0] fm [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int xmin, input int xmax, input int ymin, input int ymax,
                          input int cnt, input bit ovr);
    exp_t e;
    e.xmin = 11'(xmin); e.xmax = 11'(xmax); e.ymin = 11'(ymin); e.ymax = 11'(ymax);
    e.cnt = 20'(cnt); e.mot = (cnt >= 3); e.ovr = ovr;
    sbq.push_back(e);
    pushed++;
  endtask

  // Monitor: a result is consumed on the edge after oVALID && iREADY is seen here
  always @(negedge iCLK) begin
    if (!iRST && oVALID && iREADY) begin
      exp_t e;
      results++;
      if (sbq.size() == 0) begin
        chk("unexpected_result", 32'(oCOUNT), 32'hDEAD);
      end else begin
        e = sbq.pop_front();
        chk("x_min", 32'(oX_MIN), 32'(e.xmin));
        chk("x_max", 32'(oX_MAX), 32'(e.xmax));
        chk("y_min", 32'(oY_MIN), 32'(e.ymin));
        chk("y_max", 32'(oY_MAX), 32'(e.ymax));
        chk("count", 32'(oCOUNT), 32'(e.cnt));
        chk("motion", 32'(oMOTION), 32'(e.mot));
        chk("overrun", 32'(oOVERRUN), 32'(e.ovr));
      end
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic clear_fm();
    for (int i = 0; i < 32; i++) fm[i] = '0;
  endtask

  task automatic set_px(input int x, input int y);
    fm[y*8 + x] = 10'h1;
  endtask

  task automatic chk_reset_state();
    chk("rst_x_min", 32'(oX_MIN), 0); chk("rst_x_max", 32'(oX_MAX), 0);
    chk("rst_y_min", 32'(oY_MIN), 0); chk("rst_y_max", 32'(oY_MAX), 0);
    chk("rst_count", 32'(oCOUNT), 0); chk("rst_motion", 32'(oMOTION), 0);
    chk("rst_valid", 32'(oVALID), 0); chk("rst_overrun", 32'(oOVERRUN), 0);
  endtask

  task automatic send_frame(input int extra, input bit chk_t);
    iFVAL = 1'b1;
    tick();
    for (int i = 0; i < 32 + extra; i++) begin
      iDVAL = 1'b1;
      iMASK = (i < 32) ? fm[i] : 10'h3FF;
      tick();
    end
    iDVAL = 1'b0; iMASK = '0;
    tick();
    iFVAL = 1'b0;
    tick();
    if (chk_t) chk("valid_at_edge1", 32'(oVALID), 0);
    tick();
    if (chk_t) chk("valid_at_edge2", 32'(oVALID), 1);
    repeat (3) tick();
    if (chk_t && iREADY) chk("valid_cleared", 32'(oVALID), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    chk_reset_state();
    iRST = 1'b0;
    repeat (2) tick();

    // Scattered motion pixels
    clear_fm(); set_px(2, 1); set_px(5, 1); set_px(3, 3);
`ifdef MOTION_DENOISE_EN
    push_exp(0, 0, 0, 0, 0, 0);
`else
    push_exp(2, 5, 1, 3, 3, 0);
`endif
    send_frame(0, 1);

    // Empty frame
    clear_fm();
    push_exp(0, 0, 0, 0, 0, 0);
    send_frame(0, 1);

    // Two frames without acceptance: only the second is delivered, with overrun
    iREADY = 1'b0;
    clear_fm(); set_px(1, 0); set_px(6, 3);
    send_frame(0, 1);
    clear_fm(); set_px(3, 2); set_px(4, 2);
    send_frame(0, 0);
    chk("ovr_valid_held", 32'(oVALID), 1);
    chk("ovr_sticky", 32'(oOVERRUN), 1);
    chk("ovr_count_second", 32'(oCOUNT), 2);
    push_exp(3, 4, 2, 2, 2, 1);
    iREADY = 1'b1;
    repeat (3) tick();
    chk("ovr_after_accept_valid", 32'(oVALID), 0);
    chk("ovr_after_accept_sticky", 32'(oOVERRUN), 1);

    // Reset asserted mid-frame, released while the frame continues
    iFVAL = 1'b1; iDVAL = 1'b1; iMASK = 10'h1;
    repeat (3) tick();
    iRST = 1'b1;
    tick();
    chk_reset_state();
    repeat (2) tick();
    iRST = 1'b0;
    repeat (10) tick();
    iDVAL = 1'b0; iMASK = '0;
    tick();
    iFVAL = 1'b0;
    repeat (4) tick();
    chk("no_result_after_rst", 32'(oVALID), 0);
    clear_fm(); set_px(4, 2);
`ifdef MOTION_DENOISE_EN
    push_exp(0, 0, 0, 0, 0, 0);
`else
    push_exp(4, 4, 2, 2, 1, 0);
`endif
    send_frame(0, 1);

    // Pixels beyond the last line are ignored
    clear_fm(); set_px(7, 3);
`ifdef MOTION_DENOISE_EN
    push_exp(0, 0, 0, 0, 0, 0);
`else
    push_exp(7, 7, 3, 3, 1, 0);
`endif
    send_frame(40, 1);

    // Line 0 mask 0,1,0,0,0,0,1,1
    clear_fm(); set_px(1, 0); set_px(6, 0); set_px(7, 0);
`ifdef MOTION_DENOISE_EN
    push_exp(6, 7, 0, 0, 2, 0);
`else
    push_exp(1, 7, 0, 0, 3, 0);
`endif
    send_frame(0, 1);

    repeat (4) tick();
    chk("scoreboard_empty", 32'(sbq.size()), 0);
    chk("result_total", 32'(results), 32'(pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
